csr_hpm: RTL
============

# csr_hpm

Parametrised machine-mode performance-counter CSR bank; successor to the fixed mcycle/minstret pair in the core CSR file. It holds mcycle and minstret, a configurable number of event counters with event selectors, mcountinhibit, and an optional overflow interrupt. It sits beside the core CSR file: it decodes its own CSR address range and shares the decode-stage read port and execute-stage write port.

## Interface
- HPM_NUM, 4, number of event counters (mhpmcounter3 upward), legal 1..29
- HPM_WIDTH, 40, implemented event-counter width in bits, legal 33..64
- EVENT_NUM, 8, number of event inputs, legal 1..255
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- crden  in  1  read enable
- craddr  in  12  read CSR address
- cdata  out  32  read data; combinational
- cill  out  1  crden=1 and craddr not owned by this block; combinational
- cwren  in  1  write enable
- cwaddr  in  12  write CSR address
- cwdata  in  32  write data
- valid  in  1  instruction retired this cycle
- events  in  EVENT_NUM  per-cycle event strobes
- ovf_irq  out  1  counter-overflow interrupt request; registered

## Operation
- Address map:
  - mcountinhibit 0x320
  - mhpmevent(3+i) at 0x323+i
  - mcycle 0xB00, mcycleh 0xB80
  - minstret 0xB02, minstreth 0xB82
  - mhpmcounter(3+i) at 0xB03+i, mhpmcounter(3+i)h at 0xB83+i, for i in 0..HPM_NUM-1
- mcountinhibit:
  - bit0 (CY) inhibits mcycle; bit2 (IR) inhibits minstret; bit 3+i inhibits counter i.
  - Bit 1 and bits above 2+HPM_NUM are hardwired 0.
- mcycle and minstret are 64-bit.
  - mcycle increments by 1 every cycle unless inhibited.
  - minstret increments by 1 when valid=1 unless inhibited.
- mhpmevent(3+i):
  - bits[7:0] are SEL. SEL=0 or SEL>EVENT_NUM counts nothing; SEL=k counts cycles with events[k-1]=1.
  - bit31 is OF (sticky overflow); bit30 is OFIE (overflow interrupt enable).
  - All other bits read 0.
- Event counter i is HPM_WIDTH bits.
  - Increments by 1 when the selected event is high and counter i is not inhibited.
  - Counter bits at or above HPM_WIDTH read 0; write bits at or above HPM_WIDTH are discarded.
- Wrap-around: when an increment takes a counter from all-ones to zero, OF is set.
- Simultaneous write and increment on the same counter or half: the write wins, and the other half holds.
- A write to mhpmevent that sets OF and a hardware overflow in the same cycle leaves OF=1. A write that clears OF and an overflow in the same cycle leaves OF=1.
- ovf_irq is the registered OR over i of (OF_i & OFIE_i).
- Read mux:
  - cdata = 0 when crden=0 or the address is unmapped.
  - cill is an error flag only and has no side effects.

## Timing
- Reset values: all counters 0, mcountinhibit 0, every mhpmevent 0, ovf_irq 0. Reset is asynchronous and takes effect mid-count.
- A write at edge N is visible on cdata after edge N.
- An increment caused by an input sampled at edge N is visible after edge N.
- OF is set at the overflow edge N; ovf_irq rises at edge N+1.
- A write clearing OF or OFIE at edge M drops ovf_irq at edge M+1.
- Inhibit written at edge N stops counting from cycle N+1 onward; the increment at edge N still occurs.

## Configuration
- CSR_HPM_OVF_EN defined: OF, OFIE and ovf_irq are implemented as above.
- Undefined: bits 31:30 of mhpmevent read 0 and ignore writes; wrap is silent; ovf_irq is tied 0.

## Structure
- Address constants (csr_mcountinhibit, csr_mhpmevent3, csr_mhpmcounter3, csr_mhpmcounter3h) go in the constants package.
- The hpm_event_reg_type struct (sel, of, ofie) goes in the wires package.
- Sub-module csr_hpm_counter holds one event counter with its mhpmevent register, write merge and overflow detect. It is instantiated HPM_NUM times with generate.

## Test plan
- Reset asserted mid-count with mcycle=0x1234 → all reads 0 and ovf_irq=0 immediately. After release, mcycle reads 1 after the first edge.
- Set mcountinhibit=0x5, wait 10 cycles → mcycle and minstret are unchanged. Then valid=1 for 3 cycles with inhibit 0 → minstret +3.
- mhpmevent3 SEL=2, events[1] high 7 of 10 cycles → mhpmcounter3 reads 7. Set SEL=0 → the count freezes.
- HPM_WIDTH=40: write mhpmcounter3h=0xFFFFFFFF → reads 0x000000FF.
- HPM_WIDTH=40 with CSR_HPM_OVF_EN and OFIE=1: write low half 0xFFFFFFFF and high half 0xFF, then one event → counter reads 0, OF=1, ovf_irq=1 one cycle later. Clear OF → ovf_irq=0 next cycle.
- Write mhpmcounter3=0x10 in the same cycle as an event → reads 0x10. Read at 0x7C0 → cdata=0 and cill=1.

Source files
------------

// File: rtl/csr_hpm_pkg.sv
// Shared constants and types for the csr_hpm performance-counter bank.
// Holds the CSR address map and the mhpmevent register layout.
package csr_hpm_pkg;

  localparam logic [11:0] csr_mcountinhibit = 12'h320;
  localparam logic [11:0] csr_mhpmevent3    = 12'h323;
  localparam logic [11:0] csr_mcycle        = 12'hB00;
  localparam logic [11:0] csr_minstret      = 12'hB02;
  localparam logic [11:0] csr_mhpmcounter3  = 12'hB03;
  localparam logic [11:0] csr_mcycleh       = 12'hB80;
  localparam logic [11:0] csr_minstreth     = 12'hB82;
  localparam logic [11:0] csr_mhpmcounter3h = 12'hB83;

  typedef struct packed {
    logic       of;
    logic       ofie;
    logic [7:0] sel;
  } hpm_event_reg_type;

endpackage

// File: rtl/csr_hpm_counter.sv
// One HPM event counter with its mhpmevent register, write merge and overflow detect.
// Overflow flag/enable exist only when CSR_HPM_OVF_EN is defined.
module csr_hpm_counter
  import csr_hpm_pkg::*;
#(
  parameter int HPM_WIDTH = 40,
  parameter int EVENT_NUM = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EVENT_NUM-1:0] events,
  input  logic                 inhibit,
  input  logic                 ev_we,
  input  logic                 cnt_we_lo,
  input  logic                 cnt_we_hi,
  input  logic [31:0]          wdata,
  output logic [HPM_WIDTH-1:0] cnt,
  output hpm_event_reg_type    ev_reg,
  output logic                 irq_req
);

  logic                 hit;
  logic                 inc;
  logic [HPM_WIDTH-1:0] cnt_nxt;
  logic [7:0]           sel_q;
  logic                 of_q;
  logic                 ofie_q;

  // SEL=0 and SEL>EVENT_NUM match no iteration and so count nothing
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < EVENT_NUM; k++)
      if (sel_q == 8'(k + 1)) hit = events[k];
  end

  assign inc = hit & ~inhibit;

  always_comb begin
    cnt_nxt = cnt;
    if (cnt_we_lo)      cnt_nxt[31:0] = wdata;
    else if (cnt_we_hi) cnt_nxt[HPM_WIDTH-1:32] = wdata[HPM_WIDTH-33:0];
    else if (inc)       cnt_nxt = cnt + HPM_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      sel_q <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (ev_we) sel_q <= wdata[7:0];
    end
  end

`ifdef CSR_HPM_OVF_EN
  logic wrap;

  // a counter write suppresses the increment, so it can never wrap that cycle
  assign wrap = inc & ~cnt_we_lo & ~cnt_we_hi & (&cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      of_q   <= 1'b0;
      ofie_q <= 1'b0;
    end else if (ev_we) begin
      of_q   <= wdata[31] | wrap;
      ofie_q <= wdata[30];
    end else if (wrap) begin
      of_q   <= 1'b1;
    end
  end
`else
  assign of_q   = 1'b0;
  assign ofie_q = 1'b0;
`endif

  assign ev_reg  = '{of: of_q, ofie: ofie_q, sel: sel_q};
  assign irq_req = of_q & ofie_q;

endmodule

// File: rtl/csr_hpm.sv
// Machine-mode performance-counter CSR bank: mcycle, minstret, HPM counters, mcountinhibit.
// Overflow interrupt support is built in when CSR_HPM_OVF_EN is defined.
module csr_hpm
  import csr_hpm_pkg::*;
#(
  parameter int HPM_NUM   = 4,
  parameter int HPM_WIDTH = 40,
  parameter int EVENT_NUM = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 crden,
  input  logic [11:0]          craddr,
  output logic [31:0]          cdata,
  output logic                 cill,
  input  logic                 cwren,
  input  logic [11:0]          cwaddr,
  input  logic [31:0]          cwdata,
  input  logic                 valid,
  input  logic [EVENT_NUM-1:0] events,
  output logic                 ovf_irq
);

  // implemented inhibit bits: CY, IR and one per event counter
  localparam logic [31:0] INH_MASK = 32'(((64'd1 << (HPM_NUM + 3)) - 64'd1) & ~64'd2);

  logic [31:0]          inhibit_q;
  logic [63:0]          mcycle_q;
  logic [63:0]          minstret_q;
  logic [63:0]          hpm_ext [HPM_NUM];
  hpm_event_reg_type    hpm_ev  [HPM_NUM];
  logic [HPM_NUM-1:0]   irq_req;
  logic                 rd_hit;
  logic [31:0]          rd_val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inhibit_q  <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      ovf_irq    <= 1'b0;
    end else begin
      ovf_irq <= |irq_req;
      if (cwren && cwaddr == csr_mcountinhibit) inhibit_q <= cwdata & INH_MASK;
      if (cwren && cwaddr == csr_mcycle)        mcycle_q[31:0]  <= cwdata;
      else if (cwren && cwaddr == csr_mcycleh)  mcycle_q[63:32] <= cwdata;
      else if (!inhibit_q[0])                   mcycle_q <= mcycle_q + 64'd1;
      if (cwren && cwaddr == csr_minstret)      minstret_q[31:0]  <= cwdata;
      else if (cwren && cwaddr == csr_minstreth) minstret_q[63:32] <= cwdata;
      else if (valid && !inhibit_q[2])          minstret_q <= minstret_q + 64'd1;
    end
  end

  for (genvar i = 0; i < HPM_NUM; i++) begin : g_hpm
    localparam logic [11:0] EV_ADDR = csr_mhpmevent3 + 12'(i);
    localparam logic [11:0] LO_ADDR = csr_mhpmcounter3 + 12'(i);
    localparam logic [11:0] HI_ADDR = csr_mhpmcounter3h + 12'(i);
    logic [HPM_WIDTH-1:0] cnt;

    csr_hpm_counter #(
      .HPM_WIDTH(HPM_WIDTH),
      .EVENT_NUM(EVENT_NUM)
    ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .events   (events),
      .inhibit  (inhibit_q[3+i]),
      .ev_we    (cwren && cwaddr == EV_ADDR),
      .cnt_we_lo(cwren && cwaddr == LO_ADDR),
      .cnt_we_hi(cwren && cwaddr == HI_ADDR),
      .wdata    (cwdata),
      .cnt      (cnt),
      .ev_reg   (hpm_ev[i]),
      .irq_req  (irq_req[i])
    );

    assign hpm_ext[i] = 64'(cnt);
  end

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (craddr)
      csr_mcountinhibit: rd_val = inhibit_q;
      csr_mcycle:        rd_val = mcycle_q[31:0];
      csr_mcycleh:       rd_val = mcycle_q[63:32];
      csr_minstret:      rd_val = minstret_q[31:0];
      csr_minstreth:     rd_val = minstret_q[63:32];
      default: begin
        rd_hit = 1'b0;
        for (int i = 0; i < HPM_NUM; i++) begin
          if (craddr == csr_mhpmevent3 + 12'(i)) begin
            rd_hit = 1'b1;
            rd_val = {hpm_ev[i].of, hpm_ev[i].ofie, 22'd0, hpm_ev[i].sel};
          end
          if (craddr == csr_mhpmcounter3 + 12'(i)) begin
            rd_hit = 1'b1;
            rd_val = hpm_ext[i][31:0];
          end
          if (craddr == csr_mhpmcounter3h + 12'(i)) begin
            rd_hit = 1'b1;
            rd_val = hpm_ext[i][63:32];
          end
        end
      end
    endcase
  end

  assign cdata = crden ? rd_val : 32'd0;
  assign cill  = crden & ~rd_hit;

endmodule
